// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: index policy enum and the global-history shift helper.
// Also used by the PHT top-level wrapper.
package bp_pkg;

    typedef enum logic [1:0] {
        PC_ONLY = 2'd0,
        GSHARE  = 2'd1,
        GSELECT = 2'd2
    } index_mode_t;

    localparam int MAX_HW = 32;

    // Shift left, insert the new outcome at bit 0; callers truncate to their history width.
    function automatic logic [MAX_HW-1:0] hist_shift(input logic [MAX_HW-1:0] h, input logic b);
        return (h << 1) | MAX_HW'(b);
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples its inputs as they stood before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/history_indexer.sv
// PHT index generation with speculative/committed global history, mispredict repair
// and saturating branch/mispredict counters.
module history_indexer
    import bp_pkg::*;
#(
    parameter int          IWIDTH = 6,
    parameter int          HWIDTH = 4,
    parameter index_mode_t MODE   = GSHARE,
    parameter int          PC_LSB = 2,
    parameter int          SWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [31:0]       fetch_pc,
    input  logic              fetch_is_branch,
    input  logic              pred,
    output logic [IWIDTH-1:0] index,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic              mispredict,
    output logic [HWIDTH-1:0] spec_hist,
    output logic [HWIDTH-1:0] commit_hist,
    output logic [SWIDTH-1:0] n_branch,
    output logic [SWIDTH-1:0] n_mispredict
);

    logic [HWIDTH-1:0] spec_next;
    logic [HWIDTH-1:0] commit_next;
    logic              repair;
    logic              unused_pc_bits;

    // Only a window of the PC feeds the index; the rest is intentionally ignored.
    assign unused_pc_bits = ^fetch_pc;

    generate
        if (MODE == PC_ONLY) begin : g_pc_only
            assign index = fetch_pc[PC_LSB +: IWIDTH];
        end else if (MODE == GSHARE) begin : g_gshare
            assign index = fetch_pc[PC_LSB +: IWIDTH] ^ IWIDTH'(spec_hist);
        end else begin : g_gselect
            assign index = {fetch_pc[PC_LSB +: IWIDTH-HWIDTH], spec_hist};
        end
    endgenerate

    assign repair = resolve_valid && mispredict;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        spec_next   = spec_hist;
        commit_next = commit_hist;
        if (repair) begin
            // The same-cycle fetch is squashed, so its speculative shift is dropped.
            commit_next = HWIDTH'(hist_shift(MAX_HW'(commit_hist), resolve_taken));
            spec_next   = commit_next;
        end else begin
            if (fetch_is_branch) spec_next   = HWIDTH'(hist_shift(MAX_HW'(spec_hist), pred));
            if (resolve_valid)   commit_next = HWIDTH'(hist_shift(MAX_HW'(commit_hist), resolve_taken));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spec_hist   <= '0;
            commit_hist <= '0;
        end else if (en) begin
            spec_hist   <= spec_next;
            commit_hist <= commit_next;
        end
    end

    sat_event_counter #(.WIDTH(SWIDTH)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .inc   (resolve_valid),
        .count (n_branch)
    );

    sat_event_counter #(.WIDTH(SWIDTH)) u_mispredict_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .inc   (repair),
        .count (n_mispredict)
    );

endmodule
